intr_arb: RTL and testbench
===========================

Name: intr_arb

Overview:
- Interrupt priority arbiter for the I/O page devices (clock, RK, TT, and future DMA devices).
- Collects per-device bus requests, each with its BR level and vector. Selects the highest-priority eligible request against the current PSW priority, then offers it to the CPU.
- On CPU acknowledge, it pulses that device's ack and waits for the request to drop.
- Replaces the fixed-order OR/mux of interrupts and vectors in the I/O page.

Parameters:
- NDEV, 4: number of requesting devices.
- DROP_TIMEOUT, 15: maximum cycles to wait for an acked device to drop its request.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- dev_req  input  NDEV  level interrupt request per device.
- dev_ipl  input  3*NDEV  BR level per device; device i uses bits [3i+2:3i].
- dev_vector  input  8*NDEV  vector per device; device i uses bits [8i+7:8i].
- cpu_pri  input  3  current CPU priority, PSW[7:5].
- cpu_iack  input  1  one-cycle CPU acknowledge of the offered interrupt.
- interrupt  output  1  interrupt offered to CPU.
- interrupt_ipl  output  8  one-hot of offered level, bit[ipl]; 0 when not offering.
- vector  output  8  offered vector; 0 when not offering.
- dev_ack  output  NDEV  one-cycle ack pulse to the granted device.
- timeout_err  output  1  sticky: an acked device failed to drop its request within DROP_TIMEOUT.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; interrupt=0, interrupt_ipl=0, vector=0, dev_ack=0, timeout_err=0; internal winner, timer and RR pointer cleared.
- Eligibility: device i is eligible when dev_req[i]=1, its level != 0 and its level > cpu_pri (unsigned 3-bit compare). Level 0 is never eligible.
- Winner: eligible device with the highest level. Ties go to the lowest index (see optional feature).
- State machine has three states: IDLE, OFFER, WAIT_DROP.
- IDLE:
  - If any device is eligible, latch winner index, level and vector, then go to OFFER.
  - interrupt rises the cycle after dev_req is sampled (latency 1).
- OFFER:
  - interrupt=1; interrupt_ipl and vector driven from latched values.
  - Re-arbitrated every cycle. A different eligible device with a strictly higher level replaces the latched winner next cycle; equal level never preempts.
  - If the latched device becomes ineligible (request dropped or cpu_pri >= its level) and no other device is eligible: go to IDLE and drop interrupt next cycle (withdraw). If another device is eligible, latch it instead.
  - cpu_iack=1: dev_ack[winner]=1 for exactly the next cycle; interrupt, interrupt_ipl and vector go to 0 that same cycle; go to WAIT_DROP.
  - cpu_iack takes priority over same-cycle withdraw or preemption; the device granted is the one latched when cpu_iack was sampled.
- WAIT_DROP:
  - interrupt=0; timer counts from 0.
  - When dev_req[winner]=0, go to IDLE.
  - When timer reaches DROP_TIMEOUT with request still high, set timeout_err and go to IDLE; the device is re-arbitrated normally.
  - Other requests are held off until return to IDLE.
- cpu_iack seen in IDLE or WAIT_DROP is ignored; no dev_ack is generated.
- At most one dev_ack bit is ever set, and only for one cycle per grant.
- Reset mid-operation (any state) returns to IDLE with all outputs cleared, including a dev_ack pulse in progress.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro INTR_ARB_RR_EN.
- Defined: ties among equal-level eligible devices are resolved round-robin. A pointer starts at 0; after each cpu_iack it moves to winner+1 mod NDEV. Search starts at the pointer.
- Not defined: fixed lowest-index tie-break and no pointer logic.
- Level priority is unaffected either way.

Test Plan:
- Basic grant: cpu_pri=0, dev_req=0001, dev_ipl[0]=6, vector[0]=0o100. Expect interrupt=1 one cycle later, interrupt_ipl=0x40, vector=0o100. Pulse cpu_iack: dev_ack=0001 for 1 cycle. Drop req: back to IDLE.
- Priority and masking: dev0 at level 4 and dev1 at level 6, both requesting, cpu_pri=5. Expect dev1 offered (vector of dev1); dev0 is never offered until cpu_pri<=3 and dev1 has been served.
- Preemption and withdraw: dev0 level 4 offered; dev2 level 7 asserted. Expect vector switches to dev2 next cycle. Then dev2 drops before iack: expect dev0 offered again. Then dev0 drops: interrupt=0 next cycle.
- Simultaneous: cpu_iack in the same cycle dev0 drops its request. Expect dev_ack[0] pulsed anyway, state WAIT_DROP then IDLE.
- Timeout: acked device holds request. Expect timeout_err=1 after 15 cycles in WAIT_DROP, return to IDLE, and the device re-offered.
- RR (INTR_ARB_RR_EN): dev0 and dev1 both at level 5, both held. Expect grants alternate 0,1,0,1. Without the macro, expect 0,0,0.

Source files
------------

// File: rtl/intr_arb.sv
// Interrupt priority arbiter: offers the highest-level eligible device request to the CPU, acks on cpu_iack.
// Build option INTR_ARB_RR_EN: round-robin tie-break among equal-level requests (default: lowest index wins).
module intr_arb #(
  parameter int NDEV         = 4,
  parameter int DROP_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NDEV-1:0]   dev_req,
  input  logic [3*NDEV-1:0] dev_ipl,
  input  logic [8*NDEV-1:0] dev_vector,
  input  logic [2:0]        cpu_pri,
  input  logic              cpu_iack,
  output logic              interrupt,
  output logic [7:0]        interrupt_ipl,
  output logic [7:0]        vector,
  output logic [NDEV-1:0]   dev_ack,
  output logic              timeout_err
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int TW = (DROP_TIMEOUT > 1) ? $clog2(DROP_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_DROP} state_t;

  state_t          state;
  logic [2:0]      lvl [NDEV];
  logic [NDEV-1:0] elig;
  logic            any_elig;
  logic [2:0]      best_lvl;
  logic [IW-1:0]   best_idx;
  logic [7:0]      best_vec;
  logic            found;
  logic [IW-1:0]   win_idx;
  logic [2:0]      win_lvl;
  logic [TW-1:0]   timer;
`ifdef INTR_ARB_RR_EN
  logic [IW-1:0]   ptr;
`endif

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    int start;
    int k;
    elig     = '0;
    best_lvl = '0;
    best_idx = '0;
    best_vec = '0;
    found    = 1'b0;
    k        = 0;
`ifdef INTR_ARB_RR_EN
    start = int'(ptr);
`else
    start = 0;
`endif
    for (int i = 0; i < NDEV; i++) begin
      lvl[i]  = dev_ipl[3*i +: 3];
      elig[i] = dev_req[i] && (lvl[i] != 3'd0) && (lvl[i] > cpu_pri);
      if (elig[i] && lvl[i] > best_lvl) best_lvl = lvl[i];
    end
    // Among devices at the top level, take the first one found from the search start.
    for (int j = 0; j < NDEV; j++) begin
      k = (start + j) % NDEV;
      if (!found && elig[k] && lvl[k] == best_lvl) begin
        found    = 1'b1;
        best_idx = IW'(k);
        best_vec = dev_vector[8*k +: 8];
      end
    end
    any_elig = |elig;
  end

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      interrupt     <= 1'b0;
      interrupt_ipl <= '0;
      vector        <= '0;
      dev_ack       <= '0;
      timeout_err   <= 1'b0;
      win_idx       <= '0;
      win_lvl       <= '0;
      timer         <= '0;
`ifdef INTR_ARB_RR_EN
      ptr           <= '0;
`endif
    end else begin
      dev_ack <= '0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            win_idx       <= best_idx;
            win_lvl       <= best_lvl;
            interrupt     <= 1'b1;
            interrupt_ipl <= 8'b1 << best_lvl;
            vector        <= best_vec;
            state         <= OFFER;
          end
        end
        OFFER: begin
          if (cpu_iack) begin
            // The device latched when iack was sampled is the one granted.
            dev_ack[win_idx] <= 1'b1;
            interrupt        <= 1'b0;
            interrupt_ipl    <= '0;
            vector           <= '0;
            timer            <= '0;
            state            <= WAIT_DROP;
`ifdef INTR_ARB_RR_EN
            ptr <= (win_idx == IW'(NDEV - 1)) ? '0 : win_idx + 1'b1;
`endif
          end else if (!any_elig) begin
            interrupt     <= 1'b0;
            interrupt_ipl <= '0;
            vector        <= '0;
            state         <= IDLE;
          end else if (!elig[win_idx] || best_lvl > win_lvl) begin
            win_idx       <= best_idx;
            win_lvl       <= best_lvl;
            interrupt_ipl <= 8'b1 << best_lvl;
            vector        <= best_vec;
          end
        end
        WAIT_DROP: begin
          if (!dev_req[win_idx]) begin
            state <= IDLE;
          end else if (timer == TW'(DROP_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_arb.sv
// Scoreboard bench for intr_arb: stimulus queues expected output changes with their cycle,
// a negedge monitor pops and compares every observed change of the DUT outputs.
module tb_intr_arb;
  localparam int NDEV = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NDEV-1:0] dev_req;
  logic [11:0]     dev_ipl;
  logic [31:0]     dev_vector;
  logic [2:0]      cpu_pri;
  logic            cpu_iack;
  logic            interrupt;
  logic [7:0]      interrupt_ipl;
  logic [7:0]      vector;
  logic [NDEV-1:0] dev_ack;
  logic            timeout_err;

  intr_arb #(.NDEV(NDEV), .DROP_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .dev_req(dev_req), .dev_ipl(dev_ipl),
    .dev_vector(dev_vector), .cpu_pri(cpu_pri), .cpu_iack(cpu_iack),
    .interrupt(interrupt), .interrupt_ipl(interrupt_ipl), .vector(vector),
    .dev_ack(dev_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       intr;
    logic [7:0] ipl;
    logic [7:0] vec;
    logic [3:0] ack;
    logic       terr;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t  q[$];
  int    passed = 0;
  int    total  = 0;
  bit    mon_en = 1'b0;
  bit    first  = 1'b1;
  obs_t  prev;
  obs_t  cur;
  exp_t  e;
  string phase = "init";
  int    win[4];

  task automatic check(string name, bit ok, logic [31:0] act, logic [31:0] want);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic obs_t offer(int l, logic [7:0] v, bit terr);
    return {1'b1, 8'(8'b1 << l), v, 4'b0000, terr};
  endfunction

  function automatic obs_t quiet(logic [3:0] ack, bit terr);
    return {1'b0, 8'h00, 8'h00, ack, terr};
  endfunction

  task automatic push(int d, obs_t o);
    exp_t x;
    x.cyc = cyc + d;
    x.o   = o;
    q.push_back(x);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dev(int i, logic [2:0] l, logic [7:0] v);
    dev_ipl[3*i +: 3]    = l;
    dev_vector[8*i +: 8] = v;
  endtask

  // Monitor: any change on the outputs is an event that must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {interrupt, interrupt_ipl, vector, dev_ack, timeout_err};
      if (first || cur !== prev) begin
        if (q.size() == 0) begin
          check({phase, "/unexpected_event"}, 1'b0, 32'(cur), 32'h0);
        end else begin
          e = q.pop_front();
          check({phase, "/event_cycle"}, cyc == e.cyc, cyc, e.cyc);
          check({phase, "/event_value"}, cur === e.o, 32'(cur), 32'(e.o));
        end
        prev  = cur;
        first = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b0; dev_req = '0; dev_ipl = '0; dev_vector = '0;
    cpu_pri = 3'd0; cpu_iack = 1'b0;
    step(3);

    phase = "reset";
    reset = 1'b1;
    push(0, quiet(4'b0000, 1'b0));
    mon_en = 1'b1;
    step(2);

    phase = "basic";
    set_dev(0, 3'd6, 8'o100);
    dev_req = 4'b0001;
    push(1, offer(6, 8'o100, 1'b0));
    step(3);
    cpu_iack = 1'b1;
    push(1, quiet(4'b0001, 1'b0));
    step(1);
    cpu_iack = 1'b0; dev_req = '0;
    push(1, quiet(4'b0000, 1'b0));
    step(3);

    phase = "iack_idle";
    cpu_iack = 1'b1;
    step(1);
    cpu_iack = 1'b0;
    step(2);

    phase = "mask_edge";
    set_dev(3, 3'd0, 8'o130);
    set_dev(2, 3'd6, 8'o120);
    cpu_pri = 3'd6;
    dev_req = 4'b1100;
    step(3);
    dev_req = '0; cpu_pri = 3'd0;
    step(1);

    phase = "priority";
    cpu_pri = 3'd5;
    set_dev(0, 3'd4, 8'o104);
    set_dev(1, 3'd6, 8'o110);
    dev_req = 4'b0011;
    push(1, offer(6, 8'o110, 1'b0));
    step(3);
    cpu_iack = 1'b1;
    push(1, quiet(4'b0010, 1'b0));
    step(1);
    cpu_iack = 1'b0; dev_req = 4'b0001;
    push(1, quiet(4'b0000, 1'b0));
    step(4);
    cpu_pri = 3'd3;
    push(1, offer(4, 8'o104, 1'b0));
    step(3);
    cpu_iack = 1'b1;
    push(1, quiet(4'b0001, 1'b0));
    step(1);
    cpu_iack = 1'b0; dev_req = '0;
    push(1, quiet(4'b0000, 1'b0));
    step(3);

    phase = "preempt";
    cpu_pri = 3'd0;
    dev_req = 4'b0001;
    push(1, offer(4, 8'o104, 1'b0));
    step(3);
    set_dev(2, 3'd7, 8'o120);
    dev_req = 4'b0101;
    push(1, offer(7, 8'o120, 1'b0));
    step(3);
    set_dev(3, 3'd7, 8'o130);
    dev_req = 4'b1101;
    step(3);
    dev_req = 4'b0001;
    push(1, offer(4, 8'o104, 1'b0));
    step(3);
    dev_req = '0;
    push(1, quiet(4'b0000, 1'b0));
    step(3);

    phase = "simultaneous";
    dev_req = 4'b0001;
    push(1, offer(4, 8'o104, 1'b0));
    step(3);
    cpu_iack = 1'b1; dev_req = '0;
    push(1, quiet(4'b0001, 1'b0));
    step(1);
    cpu_iack = 1'b0;
    push(1, quiet(4'b0000, 1'b0));
    step(1);
    dev_req = 4'b0001;
    push(1, offer(4, 8'o104, 1'b0));
    step(3);
    dev_req = '0;
    push(1, quiet(4'b0000, 1'b0));
    step(3);

    phase = "timeout";
    dev_req = 4'b0001;
    push(1, offer(4, 8'o104, 1'b0));
    step(3);
    cpu_iack = 1'b1;
    push(1, quiet(4'b0001, 1'b0));
    step(1);
    cpu_iack = 1'b0;
    push(1, quiet(4'b0000, 1'b0));
    push(15, quiet(4'b0000, 1'b1));
    push(16, offer(4, 8'o104, 1'b1));
    step(18);
    cpu_iack = 1'b1;
    push(1, quiet(4'b0001, 1'b1));
    step(1);
    cpu_iack = 1'b0; dev_req = '0;
    push(1, quiet(4'b0000, 1'b1));
    step(3);

    phase = "reset_mid";
    dev_req = 4'b0001;
    push(1, offer(4, 8'o104, 1'b1));
    step(3);
    reset = 1'b0; dev_req = '0;
    push(1, quiet(4'b0000, 1'b0));
    step(2);
    reset = 1'b1;
    step(2);

    phase = "tiebreak";
`ifdef INTR_ARB_RR_EN
    win[0] = 0; win[1] = 1; win[2] = 0; win[3] = 1;
`else
    win[0] = 0; win[1] = 0; win[2] = 0; win[3] = 0;
`endif
    set_dev(0, 3'd5, 8'o104);
    set_dev(1, 3'd5, 8'o110);
    dev_req = 4'b0011;
    push(1, offer(5, (win[0] == 0) ? 8'o104 : 8'o110, 1'b0));
    for (int r = 0; r < 4; r++) begin
      step(3);
      cpu_iack = 1'b1;
      push(1, quiet(4'(1 << win[r]), 1'b0));
      step(1);
      cpu_iack = 1'b0;
      dev_req[win[r]] = 1'b0;
      push(1, quiet(4'b0000, 1'b0));
      step(1);
      if (r < 3) begin
        dev_req[win[r]] = 1'b1;
        push(1, offer(5, (win[r+1] == 0) ? 8'o104 : 8'o110, 1'b0));
      end else begin
        dev_req = '0;
      end
    end
    step(4);

    phase = "end";
    check("queue_drained", q.size() == 0, q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
